// File: rtl/dsc_mul_nway.sv
// ---------------------------------------------------------------------------
// dsc_mul_nway
//
// Deterministic stochastic-computing multiplier for NUM_INPUTS unsigned
// WIDTH-bit operands. Each latched operand is compared against its own digit
// counter to form a unary stream. The digit counters are chained like an
// odometer, so every combination of counter values is visited exactly once.
// The AND of all stream bits is counted in z. Over one full pass this count
// equals the exact binary product of the operands.
//
// Handshake: start is sampled in IDLE. busy is high in RUN and DONE. done is
// high for one cycle after the last RUN edge. z is valid while done=1 and is
// held until the next accepted start.
//
// Optional build macro: DSC_EARLY_WRAP_EN
//   undefined : naive odometer. Every digit wraps at 2^WIDTH-1, and RUN
//               lasts 2^(NUM_INPUTS*WIDTH) enabled cycles.
//   defined   : digit i wraps at op[i]-1, so every visited combination is a
//               hit. RUN lasts prod(op[i]) enabled cycles. If any operand is
//               zero, the block goes from IDLE straight to DONE with z=0.
//
// Ports
//   clk   in  1                 clock, rising edge
//   rst   in  1                 asynchronous reset, active-high
//   en    in  1                 run enable; 0 freezes all RUN state
//   start in  1                 start request, sampled only in IDLE
//   a     in  NUM_INPUTS*WIDTH  packed operands, op i = a[i*WIDTH +: WIDTH]
//   z     out NUM_INPUTS*WIDTH  product
//   busy  out 1                 high in RUN and DONE
//   done  out 1                 single-cycle completion pulse
// ---------------------------------------------------------------------------
module dsc_mul_nway #(
  parameter int NUM_INPUTS = 3,
  parameter int WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        start,
  input  logic [NUM_INPUTS*WIDTH-1:0] a,
  output logic [NUM_INPUTS*WIDTH-1:0] z,
  output logic                        busy,
  output logic                        done
);

  localparam int ZW = NUM_INPUTS * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        op_q    [NUM_INPUTS];
  logic [WIDTH-1:0]        op_d    [NUM_INPUTS];
  logic [WIDTH-1:0]        ctr_q   [NUM_INPUTS];
  logic [WIDTH-1:0]        ctr_d   [NUM_INPUTS];
  logic [WIDTH-1:0]        ctr_adv [NUM_INPUTS];
  logic [WIDTH-1:0]        limit   [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]   at_limit;
  logic [NUM_INPUTS-1:0]   stream_bit;
  logic [NUM_INPUTS-1:0]   inc;
  logic [ZW-1:0]           z_q, z_d;
  logic                    hit;
  logic                    terminal;
`ifdef DSC_EARLY_WRAP_EN
  logic [NUM_INPUTS-1:0]   a_zero;
`endif

  // Per-digit stream generator and odometer stage.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_digit
`ifdef DSC_EARLY_WRAP_EN
    // A zero operand never reaches RUN, so op-1 cannot underflow here.
    assign limit[gi]  = op_q[gi] - WIDTH'(1);
    assign a_zero[gi] = (a[gi*WIDTH +: WIDTH] == '0);
`else
    assign limit[gi]  = '1;
`endif
    assign at_limit[gi]   = (ctr_q[gi] == limit[gi]);
    assign stream_bit[gi] = (op_q[gi] > ctr_q[gi]);

    // A digit steps when all lower digits are at their wrap point. Digit 0
    // steps on every enabled cycle.
    if (gi == 0) begin : g_lsd
      assign inc[gi] = 1'b1;
    end else begin : g_upper
      assign inc[gi] = &at_limit[gi-1:0];
    end

    assign ctr_adv[gi] = inc[gi] ? (at_limit[gi] ? '0 : ctr_q[gi] + WIDTH'(1))
                                 : ctr_q[gi];
  end

  assign hit      = &stream_bit;
  // The combination being processed is the last one when every digit is at
  // its wrap point.
  assign terminal = &at_limit;

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    op_d    = op_q;
    ctr_d   = ctr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            op_d[i]  = a[i*WIDTH +: WIDTH];
            ctr_d[i] = '0;
          end
          z_d     = '0;
          state_d = ST_RUN;
`ifdef DSC_EARLY_WRAP_EN
          if (|a_zero) state_d = ST_DONE;
`endif
        end
      end
      ST_RUN: begin
        if (en) begin
          z_d   = z_q + ZW'(hit);
          ctr_d = ctr_adv;
          if (terminal) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      z_q     <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        op_q[i]  <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        op_q[i]  <= op_d[i];
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  assign z    = z_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_dsc_mul_nway.sv
// ---------------------------------------------------------------------------
// tb_dsc_mul_nway
//
// Self-checking bench for dsc_mul_nway with NUM_INPUTS=3 and WIDTH=4.
// The expected product is plain integer multiplication. The expected RUN
// length is taken from the rules of the selected mode (DSC_EARLY_WRAP_EN).
// ---------------------------------------------------------------------------
module tb_dsc_mul_nway;

  localparam int N  = 3;
  localparam int W  = 4;
  localparam int ZW = N * W;
`ifdef DSC_EARLY_WRAP_EN
  localparam int NRAND = 100;
`else
  localparam int NRAND = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [ZW-1:0] a;
  logic [ZW-1:0] z;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  dsc_mul_nway #(.NUM_INPUTS(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .a     (a),
    .z     (z),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  o0;
    logic [W-1:0]  o1;
    logic [W-1:0]  o2;
    logic [ZW-1:0] exp_z;
  } vec_t;

  // Expected number of enabled RUN cycles for one operand set.
  function automatic int exp_run(int o0, int o1, int o2);
`ifdef DSC_EARLY_WRAP_EN
    return o0 * o1 * o2;
`else
    return 1 << ZW;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run one operation from IDLE. tog alternates en every cycle, starting with
  // en=0 on the start edge. mid pulses start with new operands during RUN.
  task automatic do_op(input logic [W-1:0] o0, input logic [W-1:0] o1,
                       input logic [W-1:0] o2, input logic [ZW-1:0] exp_z,
                       input bit tog, input bit mid, input string tag);
    int r, enabled, elapsed;
    bit proto_ok;
    bit en_cur;
    r = exp_run(int'(o0), int'(o1), int'(o2));
    a     = {o2, o1, o0};
    start = 1'b1;
    en    = tog ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    enabled  = 0;
    elapsed  = 0;
    proto_ok = 1'b1;
    while (done !== 1'b1 && elapsed < 3 * (1 << ZW)) begin
      if (busy !== 1'b1) proto_ok = 1'b0;
      en_cur = tog ? (elapsed % 2 == 0) : 1'b1;
      en     = en_cur;
      if (mid && elapsed == 100) begin
        start = 1'b1;
        a     = 12'hFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      elapsed++;
      if (en_cur) enabled++;
    end
    start = 1'b0;
    en    = 1'b1;
    $display("op %0d*%0d*%0d z=%0d enabled=%0d elapsed=%0d", o0, o1, o2, z, enabled, elapsed);
    chk({tag, "_done"},    32'(done), 32'd1);
    chk({tag, "_busy"},    32'(busy), 32'd1);
    chk({tag, "_z"},       32'(z), 32'(exp_z));
    chk({tag, "_proto"},   32'(proto_ok), 32'd1);
    chk({tag, "_enabled"}, 32'(enabled), 32'(r));
    chk({tag, "_elapsed"}, 32'(elapsed), 32'((tog && r > 0) ? 2 * r - 1 : r));
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_z_hold"},    32'(z), 32'(exp_z));
  endtask

  initial begin
    vec_t vecs [4];
    int   half;
    logic [W-1:0] r0, r1, r2;

    vecs[0] = '{o0: 4'd15, o1: 4'd15, o2: 4'd15, exp_z: 12'd3375};
    vecs[1] = '{o0: 4'd0,  o1: 4'd9,  o2: 4'd7,  exp_z: 12'd0};
    vecs[2] = '{o0: 4'd1,  o1: 4'd1,  o2: 4'd1,  exp_z: 12'd1};
    vecs[3] = '{o0: 4'd2,  o1: 4'd15, o2: 4'd8,  exp_z: 12'd240};

    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    a     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_z",    32'(z), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++)
      do_op(vecs[i].o0, vecs[i].o1, vecs[i].o2, vecs[i].exp_z, 1'b0, 1'b0,
            $sformatf("vec%0d", i));

    do_op(4'd3, 4'd5, 4'd2, 12'd30, 1'b1, 1'b0, "en_toggle");
    do_op(4'd3, 4'd4, 4'd5, 12'd60, 1'b0, 1'b1, "mid_start");

    // Abort halfway through 7*7*7 with an asynchronous reset.
    half  = exp_run(7, 7, 7) / 2;
    a     = {4'd7, 4'd7, 4'd7};
    start = 1'b1;
    en    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (half) @(posedge clk);
    #1;
    chk("abort_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_z",    32'(z), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    do_op(4'd2, 4'd3, 4'd4, 12'd24, 1'b0, 1'b0, "after_abort");

    for (int k = 0; k < NRAND; k++) begin
      r0 = W'($urandom_range(0, 15));
      r1 = W'($urandom_range(0, 15));
      r2 = W'($urandom_range(0, 15));
      do_op(r0, r1, r2, ZW'(int'(r0) * int'(r1) * int'(r2)), 1'b0, 1'b0,
            $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
